instruction_fetch_controller: RTL and testbench

Sequences the instruction memory for the RV32IM pipeline. It owns the program counter, drives the word address into the combinational-read instruction memory, and registers the returned word into the IF/ID stage with a valid/ready handshake to decode. It also applies branch/jump redirects, flushes, and faults on misaligned targets. It sits between the instruction memory and the decode stage.

---
 rtl/instruction_fetch_controller_if.sv | 29 ++
 rtl/instruction_fetch_controller.sv | 118 +++++++++++
 tb/tb_instruction_fetch_controller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_controller_if.sv
// Fetch controller bus bundle: start, instruction-memory port, redirect,
// IF/ID handshake with decode, and fault/performance status.
interface instruction_fetch_controller_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] imemAddress;
    logic [31:0]           imemInstruction;
    logic                  branchTaken;
    logic [31:0]           branchTarget;
    logic                  idReady;
    logic                  ifValid;
    logic [31:0]           ifInstruction;
    logic [31:0]           ifPC;
    logic                  fetchFault;
    logic [31:0]           faultPC;
    logic [31:0]           fetchCount;

    // master is the fetch controller; slave is memory, execute and decode.
    modport master (
        input  start, imemInstruction, branchTaken, branchTarget, idReady,
        output imemAddress, ifValid, ifInstruction, ifPC, fetchFault, faultPC, fetchCount
    );

    modport slave (
        output start, imemInstruction, branchTaken, branchTarget, idReady,
        input  imemAddress, ifValid, ifInstruction, ifPC, fetchFault, faultPC, fetchCount
    );
endinterface

// File: rtl/instruction_fetch_controller.sv
// RV32IM instruction fetch: owns the PC, feeds the IF/ID register, applies redirects
// and faults on misaligned targets. FETCH_PERF_COUNTER_EN adds an accepted-instruction counter.
module instruction_fetch_controller #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           reset,
    instruction_fetch_controller_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic        misaligned;

    assign misaligned = bus.branchTaken && (bus.branchTarget[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (misaligned) state_d = S_FAULT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_BOOT;
        endcase
    end

    // A redirect beats both load and stall, so a stalled IF/ID word is dropped.
    always_comb begin
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        fault_pc_d = fault_pc_q;
        if (state_q == S_RUN) begin
            if (bus.branchTaken) begin
                if_valid_d = 1'b0;
                if_instr_d = NOP;
                if (misaligned) begin
                    fault_pc_d = bus.branchTarget;
                end else begin
                    pc_d = bus.branchTarget;
                end
            end else if (!if_valid_q || bus.idReady) begin
                if_instr_d = bus.imemInstruction;
                if_pc_d    = pc_q;
                if_valid_d = 1'b1;
                pc_d       = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= NOP;
            if_pc_q    <= 32'h0;
            fault_pc_q <= 32'h0;
        end else begin
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (if_valid_q && bus.idReady && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= 32'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.fetchCount = fetch_count_q;
`else
    assign bus.fetchCount = 32'h0;
`endif

    // Memory index ignores PC bits above the array, so addressing wraps.
    assign bus.imemAddress   = pc_q[ADDR_WIDTH+1:2];
    assign bus.ifValid       = if_valid_q;
    assign bus.ifInstruction = if_instr_q;
    assign bus.ifPC          = if_pc_q;
    assign bus.fetchFault    = (state_q == S_FAULT);
    assign bus.faultPC       = fault_pc_q;
endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: directed vector table, misaligned fault,
// async reset mid-stall, address wrap, and randomized run against a behavioural model.
module tb_instruction_fetch_controller;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_controller_if #(.ADDR_WIDTH(10)) i0 ();
    instruction_fetch_controller_if #(.ADDR_WIDTH(10)) i1 ();

    logic [31:0] mem [0:1023];
    assign i0.imemInstruction = mem[i0.imemAddress];
    assign i1.imemInstruction = mem[i1.imemAddress];

    instruction_fetch_controller #(.ADDR_WIDTH(10), .RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .reset(rst0), .bus(i0.master));
    instruction_fetch_controller #(.ADDR_WIDTH(10), .RESET_PC(32'h0000_0FFC)) dut1 (
        .clk(clk), .reset(rst1), .bus(i1.master));

    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] w(int i);
        return 32'h0010_0093 + i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef FETCH_PERF_COUNTER_EN
        return c;
`else
        return 32'h0;
`endif
    endfunction

    // Behavioural reference: a one-slot IF/ID buffer filled from the next-fetch address.
    int          m_mode;       // 0 waiting for start, 1 fetching, 2 faulted
    logic [31:0] m_next;       // address of the next word to fetch
    logic        m_full;
    logic [31:0] m_word, m_at, m_fault_at, m_cnt;

    task automatic model_reset();
        m_mode = 0; m_next = 32'h0; m_full = 1'b0; m_word = NOP;
        m_at = 32'h0; m_fault_at = 32'h0; m_cnt = 32'h0;
    endtask

    task automatic model_edge(input logic s, input logic bt, input logic [31:0] tg, input logic r);
        logic consumed;
        consumed = m_full && r;
        if (consumed && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_mode == 0) begin
            if (s) m_mode = 1;
        end else if (m_mode == 1) begin
            if (bt) begin
                m_full = 1'b0;
                m_word = NOP;
                if (tg % 4 != 0) begin m_mode = 2; m_fault_at = tg; end
                else m_next = tg;
            end else if (!m_full || consumed) begin
                m_word = mem[(m_next / 4) % 1024];
                m_at   = m_next;
                m_full = 1'b1;
                m_next = m_next + 4;
            end
        end
    endtask

    task automatic drive0(input logic s, input logic bt, input logic [31:0] tg, input logic r);
        @(negedge clk);
        i0.start = s; i0.branchTaken = bt; i0.branchTarget = tg; i0.idReady = r;
        @(posedge clk);
        model_edge(s, bt, tg, r);
        #1;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".ifValid"}, {31'b0, i0.ifValid}, {31'b0, m_full});
        chk({tag, ".ifInstruction"}, i0.ifInstruction, m_word);
        chk({tag, ".ifPC"}, i0.ifPC, m_at);
        chk({tag, ".imemAddress"}, {22'b0, i0.imemAddress}, (m_next / 4) % 1024);
        chk({tag, ".fetchFault"}, {31'b0, i0.fetchFault}, {31'b0, (m_mode == 2)});
        chk({tag, ".faultPC"}, i0.faultPC, m_fault_at);
        chk({tag, ".fetchCount"}, i0.fetchCount, cnt_exp(m_cnt));
    endtask

    task automatic reset0();
        @(negedge clk);
        rst0 = 1'b1;
        i0.start = 0; i0.branchTaken = 0; i0.branchTarget = 0; i0.idReady = 0;
        @(negedge clk);
        rst0 = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        s, bt;
        logic [31:0] tg;
        logic        r, ev;
        logic [31:0] epc, einstr, eaddr, ecnt;
    } vec_t;

    function automatic vec_t mk(logic s, logic bt, logic [31:0] tg, logic r, logic ev,
                                logic [31:0] epc, logic [31:0] ei, logic [31:0] ea, logic [31:0] ec);
        vec_t v;
        v.s = s; v.bt = bt; v.tg = tg; v.r = r; v.ev = ev;
        v.epc = epc; v.einstr = ei; v.eaddr = ea; v.ecnt = ec;
        return v;
    endfunction

    vec_t vt[14];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = w(i);
        i0.start = 0; i0.branchTaken = 0; i0.branchTarget = 0; i0.idReady = 0;
        i1.start = 0; i1.branchTaken = 0; i1.branchTarget = 0; i1.idReady = 0;

        vt[0]  = mk(1, 0, 0,     1, 0, 32'h00, NOP,   0,  0);
        vt[1]  = mk(0, 0, 0,     1, 1, 32'h00, w(0),  1,  0);
        vt[2]  = mk(0, 0, 0,     1, 1, 32'h04, w(1),  2,  1);
        vt[3]  = mk(0, 0, 0,     1, 1, 32'h08, w(2),  3,  2);
        vt[4]  = mk(0, 0, 0,     0, 1, 32'h08, w(2),  3,  2);
        vt[5]  = mk(0, 0, 0,     0, 1, 32'h08, w(2),  3,  2);
        vt[6]  = mk(0, 0, 0,     0, 1, 32'h08, w(2),  3,  2);
        vt[7]  = mk(0, 0, 0,     1, 1, 32'h0C, w(3),  4,  3);
        vt[8]  = mk(0, 0, 0,     1, 1, 32'h10, w(4),  5,  4);
        vt[9]  = mk(0, 1, 32'h40, 1, 0, 32'h10, NOP,  16, 5);
        vt[10] = mk(0, 0, 0,     1, 1, 32'h40, w(16), 17, 5);
        vt[11] = mk(0, 1, 32'h80, 0, 0, 32'h40, NOP,  32, 5);
        vt[12] = mk(0, 0, 0,     1, 1, 32'h80, w(32), 33, 5);
        vt[13] = mk(0, 0, 0,     1, 1, 32'h84, w(33), 34, 6);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset.ifValid", {31'b0, i0.ifValid}, 32'h0);
        chk("reset.ifInstruction", i0.ifInstruction, NOP);
        chk("reset.ifPC", i0.ifPC, 32'h0);
        chk("reset.fetchFault", {31'b0, i0.fetchFault}, 32'h0);
        chk("reset.faultPC", i0.faultPC, 32'h0);
        chk("reset.fetchCount", i0.fetchCount, 32'h0);
        chk("reset.imemAddress", {22'b0, i0.imemAddress}, 32'h0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        model_reset();

        // Directed vector table: sequential fetch, stall, redirect, redirect during stall
        for (int k = 0; k < 14; k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            drive0(vt[k].s, vt[k].bt, vt[k].tg, vt[k].r);
            chk({tag, ".ifValid"}, {31'b0, i0.ifValid}, {31'b0, vt[k].ev});
            chk({tag, ".ifPC"}, i0.ifPC, vt[k].epc);
            chk({tag, ".ifInstruction"}, i0.ifInstruction, vt[k].einstr);
            chk({tag, ".imemAddress"}, {22'b0, i0.imemAddress}, vt[k].eaddr);
            chk({tag, ".fetchFault"}, {31'b0, i0.fetchFault}, 32'h0);
            chk({tag, ".fetchCount"}, i0.fetchCount, cnt_exp(vt[k].ecnt));
        end

        // Misaligned redirect, then FAULT must ignore all activity
        drive0(0, 1, 32'h42, 1);
        chk("mis.fetchFault", {31'b0, i0.fetchFault}, 32'h1);
        chk("mis.faultPC", i0.faultPC, 32'h42);
        chk("mis.ifValid", {31'b0, i0.ifValid}, 32'h0);
        chk("mis.ifInstruction", i0.ifInstruction, NOP);
        for (int k = 0; k < 10; k++) begin
            logic [31:0] t;
            t = $urandom();
            drive0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)));
            chk("flt.fetchFault", {31'b0, i0.fetchFault}, 32'h1);
            chk("flt.ifValid", {31'b0, i0.ifValid}, 32'h0);
            chk("flt.faultPC", i0.faultPC, 32'h42);
            chk("flt.imemAddress", {22'b0, i0.imemAddress}, 32'd34);
            chk("flt.fetchCount", i0.fetchCount, cnt_exp(32'd7));
        end

        // Asynchronous reset in the middle of a stall
        reset0();
        drive0(1, 0, 0, 1);
        drive0(0, 0, 0, 1);
        drive0(0, 0, 0, 1);
        drive0(0, 0, 0, 0);
        drive0(0, 0, 0, 0);
        chk("stall.ifValid", {31'b0, i0.ifValid}, 32'h1);
        #2;
        rst0 = 1'b1;
        #1;
        chk("areset.ifValid", {31'b0, i0.ifValid}, 32'h0);
        chk("areset.ifInstruction", i0.ifInstruction, NOP);
        chk("areset.ifPC", i0.ifPC, 32'h0);
        chk("areset.imemAddress", {22'b0, i0.imemAddress}, 32'h0);
        chk("areset.fetchCount", i0.fetchCount, 32'h0);
        chk("areset.fetchFault", {31'b0, i0.fetchFault}, 32'h0);

        // Address wrap from index 1023 to 0
        @(negedge clk);
        i1.start = 1; i1.idReady = 1;
        @(negedge clk);
        i1.start = 0;
        @(negedge clk);
        chk("wrap.ifPC0", i1.ifPC, 32'h0FFC);
        chk("wrap.ifInstruction0", i1.ifInstruction, w(1023));
        chk("wrap.imemAddress", {22'b0, i1.imemAddress}, 32'h0);
        @(negedge clk);
        chk("wrap.ifPC1", i1.ifPC, 32'h1000);
        chk("wrap.ifInstruction1", i1.ifInstruction, w(0));

        // Randomized segments against the behavioural model
        for (int seg = 0; seg < 20; seg++) begin
            reset0();
            compare_model("rnd.boot");
            for (int c = 0; c < 150; c++) begin
                logic        s, bt, r;
                logic [31:0] t;
                s  = (c < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
                bt = ($urandom_range(0, 7) == 0);
                t  = $urandom();
                t[1:0] = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                if ($urandom_range(0, 1) == 0) t[31:12] = 20'h0;
                r  = ($urandom_range(0, 3) != 0);
                drive0(s, bt, t, r);
                compare_model("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
